// File: rtl/ibex_pkg.sv
// Shared M-extension types for the multdiv issue controller.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_BUSY  = 2'd1,
        MD_DRAIN = 2'd2,
        MD_RESP  = 2'd3
    } md_issue_state_e;

    function automatic logic md_op_is_div(md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/ibex_multdiv_issue_ctrl.sv
// Issue sequencer between the decoder and the slow multdiv body: latches one
// request, keeps the body enabled until it returns a result, buffers it for writeback.
module ibex_multdiv_issue_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned LatW = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  md_op_e           req_op_i,
    input  logic [1:0]       req_signed_mode_i,
    input  logic [31:0]      req_op_a_i,
    input  logic [31:0]      req_op_b_i,
    input  logic [4:0]       req_rd_i,
    input  logic             flush_i,
    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             mult_sel_o,
    output logic             div_sel_o,
    output md_op_e           operator_o,
    output logic [1:0]       signed_mode_o,
    output logic [31:0]      op_a_o,
    output logic [31:0]      op_b_o,
    input  logic             md_valid_i,
    input  logic [31:0]      md_result_i,
    output logic             multdiv_ready_id_o,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [4:0]       wb_rd_o,
    output logic [31:0]      wb_result_o,
    output logic [LatW-1:0]  wb_lat_o,
    output logic             busy_o
);

    localparam logic [LatW-1:0] LatMax = {LatW{1'b1}};
    localparam logic [LatW-1:0] LatOne = {{(LatW-1){1'b0}}, 1'b1};

    md_issue_state_e state_r;
    md_issue_state_e state_nxt_s;
    logic            accept_s;
    logic            drive_nxt_s;
    md_op_e          op_nxt_s;
    logic [LatW-1:0] cnt_r;
    logic [LatW-1:0] cnt_inc_s;

    md_op_e          op_r;
    logic [1:0]      sm_r;
    logic [31:0]     a_r;
    logic [31:0]     b_r;
    logic [4:0]      rd_r;
    logic [31:0]     res_r;
    logic [4:0]      res_rd_r;
    logic [LatW-1:0] lat_r;
    logic            mult_en_r;
    logic            div_en_r;
    logic            mdrdy_r;
    logic            wb_valid_r;
    logic            busy_r;

    assign req_ready_o = ~flush_i & ((state_r == MD_IDLE) |
                                     ((state_r == MD_RESP) & wb_ready_i));
    assign accept_s    = req_valid_i & req_ready_o;
    assign op_nxt_s    = accept_s ? req_op_i : op_r;
    assign cnt_inc_s   = (cnt_r == LatMax) ? cnt_r : (cnt_r + LatOne);

    // Next-state decode; a flush during BUSY lets the body finish in DRAIN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            MD_IDLE: begin
                if (accept_s) state_nxt_s = MD_BUSY;
                else          state_nxt_s = MD_IDLE;
            end
            MD_BUSY: begin
                if (flush_i)         state_nxt_s = md_valid_i ? MD_IDLE : MD_DRAIN;
                else if (md_valid_i) state_nxt_s = MD_RESP;
                else                 state_nxt_s = MD_BUSY;
            end
            MD_DRAIN: begin
                if (md_valid_i) state_nxt_s = MD_IDLE;
                else            state_nxt_s = MD_DRAIN;
            end
            MD_RESP: begin
                if (flush_i)         state_nxt_s = MD_IDLE;
                else if (wb_ready_i) state_nxt_s = accept_s ? MD_BUSY : MD_IDLE;
                else                 state_nxt_s = MD_RESP;
            end
            default: state_nxt_s = MD_IDLE;
        endcase
        drive_nxt_s = (state_nxt_s == MD_BUSY) | (state_nxt_s == MD_DRAIN);
    end

    // State register and registered body/writeback control outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= MD_IDLE;
            mult_en_r  <= 1'b0;
            div_en_r   <= 1'b0;
            mdrdy_r    <= 1'b0;
            wb_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            mult_en_r  <= drive_nxt_s & ~md_op_is_div(op_nxt_s);
            div_en_r   <= drive_nxt_s & md_op_is_div(op_nxt_s);
            mdrdy_r    <= drive_nxt_s;
            wb_valid_r <= (state_nxt_s == MD_RESP);
            busy_r     <= (state_nxt_s != MD_IDLE);
        end
    end

    // Operand latches, latency counter and result buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_r     <= MD_OP_MULL;
            sm_r     <= 2'b00;
            a_r      <= 32'h0000_0000;
            b_r      <= 32'h0000_0000;
            rd_r     <= 5'd0;
            cnt_r    <= {LatW{1'b0}};
            res_r    <= 32'h0000_0000;
            res_rd_r <= 5'd0;
            lat_r    <= {LatW{1'b0}};
        end else begin
            if (accept_s) begin
                op_r  <= req_op_i;
                sm_r  <= req_signed_mode_i;
                a_r   <= req_op_a_i;
                b_r   <= req_op_b_i;
                rd_r  <= req_rd_i;
                cnt_r <= {LatW{1'b0}};
            end else if (state_r == MD_BUSY) begin
                cnt_r <= cnt_inc_s;
            end
            // Reported latency includes the cycle in which the body's valid arrives.
            if ((state_r == MD_BUSY) && md_valid_i && !flush_i) begin
                res_r    <= md_result_i;
                res_rd_r <= rd_r;
                lat_r    <= cnt_inc_s;
            end
        end
    end

    assign mult_en_o          = mult_en_r;
    assign mult_sel_o         = mult_en_r;
    assign div_en_o           = div_en_r;
    assign div_sel_o          = div_en_r;
    assign multdiv_ready_id_o = mdrdy_r;
    assign operator_o         = op_r;
    assign signed_mode_o      = sm_r;
    assign op_a_o             = a_r;
    assign op_b_o             = b_r;
    assign wb_valid_o         = wb_valid_r & ~flush_i;
    assign wb_rd_o            = res_rd_r;
    assign wb_result_o        = res_r;
    assign wb_lat_o           = lat_r;
    assign busy_o             = busy_r;

endmodule

// File: tb/tb_ibex_multdiv_issue_ctrl.sv
// Randomized bench: a transaction-level model of the issue controller plus a
// behavioural multdiv body that answers after a random number of enabled cycles.
module tb_ibex_multdiv_issue_ctrl;
    import ibex_pkg::*;

    localparam int LatW = 6;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            req_valid_i, req_ready_o;
    md_op_e          req_op_i;
    logic [1:0]      req_signed_mode_i;
    logic [31:0]     req_op_a_i, req_op_b_i;
    logic [4:0]      req_rd_i;
    logic            flush_i;
    logic            mult_en_o, div_en_o, mult_sel_o, div_sel_o;
    md_op_e          operator_o;
    logic [1:0]      signed_mode_o;
    logic [31:0]     op_a_o, op_b_o;
    logic            md_valid_i;
    logic [31:0]     md_result_i;
    logic            multdiv_ready_id_o;
    logic            wb_valid_o, wb_ready_i;
    logic [4:0]      wb_rd_o;
    logic [31:0]     wb_result_o;
    logic [LatW-1:0] wb_lat_o;
    logic            busy_o;

    ibex_multdiv_issue_ctrl #(.LatW(LatW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_signed_mode_i(req_signed_mode_i),
        .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_rd_i(req_rd_i),
        .flush_i(flush_i),
        .mult_en_o(mult_en_o), .div_en_o(div_en_o),
        .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
        .operator_o(operator_o), .signed_mode_o(signed_mode_o),
        .op_a_o(op_a_o), .op_b_o(op_b_o),
        .md_valid_i(md_valid_i), .md_result_i(md_result_i),
        .multdiv_ready_id_o(multdiv_ready_id_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_result_o(wb_result_o), .wb_lat_o(wb_lat_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        md_op_e      op;
        logic [1:0]  sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } req_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: the op held by the body, whether it was killed,
    // and the result waiting for writeback.
    req_t        cur;
    bit          have_op, killed, have_resp;
    int          busy_cycles;
    logic [31:0] resp_res;
    logic [4:0]  resp_rd;
    logic [5:0]  resp_lat;

    int  body_cnt, body_tgt;
    bit  en_prev, mdv_prev;

    bit          directed;
    req_t        dq[$];
    int          fq[$];
    int          flush_at, since_acc;
    logic [31:0] done_res[$];
    logic [4:0]  done_rd[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_calc(md_op_e op, logic [1:0] sm, logic [31:0] a, logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic [31:0] q;
        logic        sgn, ovf;
        ea  = sm[0] ? {{32{a[31]}}, a} : {32'd0, a};
        eb  = sm[1] ? {{32{b[31]}}, b} : {32'd0, b};
        p   = ea * eb;
        sgn = sm[0] & sm[1];
        ovf = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MD_OP_MULL: q = p[31:0];
            MD_OP_MULH: q = p[63:32];
            MD_OP_DIV: begin
                if (b == 32'd0) q = 32'hFFFF_FFFF;
                else if (ovf)   q = a;
                else if (sgn)   q = $signed(a) / $signed(b);
                else            q = a / b;
            end
            default: begin
                if (b == 32'd0) q = a;
                else if (ovf)   q = 32'd0;
                else if (sgn)   q = $signed(a) % $signed(b);
                else            q = a % b;
            end
        endcase
        return q;
    endfunction

    function automatic int pick_tgt();
        if (directed) return 5;
        if ($urandom_range(0, 15) == 0) return $urandom_range(60, 75);
        return $urandom_range(1, 6);
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic [31:0] s [4];
        s[0] = 32'h0; s[1] = 32'h1; s[2] = 32'hFFFF_FFFF; s[3] = 32'h8000_0000;
        if ($urandom_range(0, 3) == 0) return s[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    task automatic model_clear();
        cur = '0; have_op = 0; killed = 0; have_resp = 0; busy_cycles = 0;
        resp_res = '0; resp_rd = '0; resp_lat = '0;
        body_cnt = 0; body_tgt = 3; en_prev = 0; mdv_prev = 0;
        md_valid_i = 1'b0; md_result_i = 32'd0;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
        chk({tag, "_en"}, 64'({mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o}), 64'd0);
        chk({tag, "_operands"}, 64'({operator_o, signed_mode_o, op_a_o, op_b_o}), 64'd0);
        chk({tag, "_wb"}, 64'({wb_valid_o, wb_rd_o, wb_result_o, wb_lat_o}), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    // Inputs for the coming cycle: body reaction first, then requester and writeback.
    task automatic drive_inputs();
        if (mdv_prev) begin
            md_valid_i = 1'b0; body_cnt = 0; body_tgt = pick_tgt();
        end else if (en_prev) begin
            body_cnt++;
            if (body_cnt >= body_tgt) begin
                md_valid_i  = 1'b1;
                md_result_i = ref_calc(operator_o, signed_mode_o, op_a_o, op_b_o);
            end
        end else begin
            md_valid_i = 1'b0; body_cnt = 0;
        end
        if (directed) begin
            req_valid_i = (dq.size() > 0);
            if (dq.size() > 0) begin
                req_op_i = dq[0].op; req_signed_mode_i = dq[0].sm;
                req_op_a_i = dq[0].a; req_op_b_i = dq[0].b; req_rd_i = dq[0].rd;
            end
            wb_ready_i = 1'b1;
            flush_i    = (flush_at != 0) && (since_acc == flush_at);
        end else begin
            req_valid_i = ($urandom_range(0, 9) < 6);
            req_op_i    = md_op_e'($urandom_range(0, 3));
            req_signed_mode_i = md_op_is_div(req_op_i) ? ($urandom_range(0, 1) ? 2'b11 : 2'b00)
                                                      : 2'($urandom_range(0, 3));
            req_op_a_i  = rnd_operand();
            req_op_b_i  = rnd_operand();
            req_rd_i    = 5'($urandom_range(0, 31));
            wb_ready_i  = ($urandom_range(0, 9) < 6);
            flush_i     = ($urandom_range(0, 99) < 4);
        end
    endtask

    // Compare every output against the model, then advance the model over the edge.
    task automatic check_and_update();
        logic exp_ready, acc, is_div;
        exp_ready = ~flush_i & ((~have_op & ~have_resp) | (have_resp & wb_ready_i));
        is_div    = (cur.op == MD_OP_DIV) || (cur.op == MD_OP_REM);
        chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
        chk("busy", 64'(busy_o), 64'(have_op | have_resp));
        chk("mult_en_sel", 64'({mult_en_o, mult_sel_o}), 64'({2{have_op & ~is_div}}));
        chk("div_en_sel", 64'({div_en_o, div_sel_o}), 64'({2{have_op & is_div}}));
        chk("md_ready_id", 64'(multdiv_ready_id_o), 64'(have_op));
        chk("operator", 64'(operator_o), 64'(cur.op));
        chk("signed_mode", 64'(signed_mode_o), 64'(cur.sm));
        chk("op_a_b", {op_a_o, op_b_o}, {cur.a, cur.b});
        chk("wb_valid", 64'(wb_valid_o), 64'(have_resp & ~flush_i));
        if (have_resp) begin
            chk("wb_rd", 64'(wb_rd_o), 64'(resp_rd));
            chk("wb_result", 64'(wb_result_o), 64'(resp_res));
            chk("wb_lat", 64'(wb_lat_o), 64'(resp_lat));
        end
        en_prev  = mult_en_o | div_en_o;
        mdv_prev = md_valid_i;
        acc = req_valid_i & exp_ready;
        if (have_resp) begin
            if (flush_i) have_resp = 0;
            else if (wb_ready_i) begin
                have_resp = 0;
                if (directed) begin done_res.push_back(wb_result_o); done_rd.push_back(wb_rd_o); end
            end
        end
        if (have_op) begin
            if (!killed) busy_cycles++;
            if (md_valid_i) begin
                have_op = 0;
                if (!killed && !flush_i) begin
                    have_resp = 1;
                    resp_res  = ref_calc(cur.op, cur.sm, cur.a, cur.b);
                    resp_rd   = cur.rd;
                    resp_lat  = (busy_cycles > 63) ? 6'd63 : 6'(busy_cycles);
                end
            end else if (flush_i) begin
                killed = 1;
            end
        end
        if (acc) begin
            cur.op = req_op_i; cur.sm = req_signed_mode_i;
            cur.a = req_op_a_i; cur.b = req_op_b_i; cur.rd = req_rd_i;
            have_op = 1; killed = 0; busy_cycles = 0; since_acc = 1;
            if (directed && dq.size() > 0) begin
                void'(dq.pop_front());
                flush_at = fq.pop_front();
            end
        end else begin
            since_acc++;
        end
    endtask

    task automatic step();
        drive_inputs();
        @(negedge clk_i);
        check_and_update();
        @(posedge clk_i);
        #1;
    endtask

    task automatic add_dir(md_op_e op, logic [1:0] sm, logic [31:0] a, logic [31:0] b, logic [4:0] rd, int fl);
        req_t r;
        r.op = op; r.sm = sm; r.a = a; r.b = b; r.rd = rd;
        dq.push_back(r);
        fq.push_back(fl);
    endtask

    initial begin
        bit reset_done;
        int guard;
        rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = MD_OP_MULL; req_signed_mode_i = 2'b00;
        req_op_a_i = 32'd0; req_op_b_i = 32'd0; req_rd_i = 5'd0;
        flush_i = 1'b0; wb_ready_i = 1'b0;
        directed = 1'b0; flush_at = 0; since_acc = 0; reset_done = 1'b0;
        model_clear();
        #2;
        check_reset_outputs("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Pin the reference arithmetic with hand-computed values.
        chk("ref_mull", 64'(ref_calc(MD_OP_MULL, 2'b00, 32'd7, 32'd6)), 64'd42);
        chk("ref_div_s", 64'(ref_calc(MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFD);
        chk("ref_rem0", 64'(ref_calc(MD_OP_REM, 2'b00, 32'h1234, 32'd0)), 64'h1234);
        chk("ref_mulh_u", 64'(ref_calc(MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFE);

        directed = 1'b1;
        add_dir(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 5'd5, 0);
        add_dir(MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd1, 0);
        add_dir(MD_OP_REM, 2'b00, 32'h1234, 32'd0, 5'd2, 0);
        add_dir(MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
        add_dir(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 5'd4, 3);
        add_dir(MD_OP_MULL, 2'b00, 32'd3, 32'd3, 5'd6, 0);
        guard = 0;
        while ((dq.size() > 0 || have_op || have_resp) && guard < 500) begin
            step();
            guard++;
        end
        chk("directed_timeout", 64'(guard < 500), 64'd1);
        chk("directed_count", 64'(done_res.size()), 64'd5);
        if (done_res.size() == 5) begin
            chk("dir_mull", {27'd0, done_rd[0], done_res[0]}, {27'd0, 5'd5, 32'd42});
            chk("dir_div", 64'(done_res[1]), 64'hFFFF_FFFD);
            chk("dir_rem", 64'(done_res[2]), 64'h1234);
            chk("dir_mulh", 64'(done_res[3]), 64'hFFFF_FFFE);
            chk("dir_after_flush", {27'd0, done_rd[4], done_res[4]}, {27'd0, 5'd6, 32'd9});
        end
        directed = 1'b0;
        flush_at = 0;

        for (int i = 0; i < 4000; i++) begin
            if (i >= 1500 && !reset_done && have_op && !killed) begin
                rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0;
                model_clear();
                #1;
                check_reset_outputs("mid_reset");
                @(posedge clk_i); #1;
                rst_i = 1'b0;
                reset_done = 1'b1;
            end
            step();
        end
        chk("mid_reset_done", 64'(reset_done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
